// File: rtl/dcache_wb_if.sv
// Word-serial backing-memory port of dcache_wb: one beat per request/ack pair.
interface dcache_wb_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with word-serial refill and writeback.
module dcache_wb #(
    parameter int WOFF_BITS  = 3,
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [3:0]  sign_mask,
    input  logic        instr_cache_busy,
    output logic [31:0] read_data,
    output logic        clk_stall,
    output logic        err,
    dcache_wb_if.master mem
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (INDEX_BITS + WOFF_BITS);
    localparam int AHI   = TAG_BITS + INDEX_BITS + WOFF_BITS + 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

    state_t                state_q, state_d;
    logic [AHI:0]          addr_q, addr_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [3:0]            mask_q, mask_d;
    logic                  wr_q, wr_d;
    logic [WOFF_BITS-1:0]  beat_q, beat_d, beat_nx;
    logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0]           read_data_q, read_data_d;
    logic                  clk_stall_q, clk_stall_d, err_q, err_d;

    logic [31:0]           data_mem [WORDS];
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [LINES-1:0]      valid_q, dirty_q;

    logic [1:0]            boff;
    logic [WOFF_BITS-1:0]  woff;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit, acked, last;
    logic                  data_we, fill_done, wb_done, set_dirty;
    logic [INDEX_BITS+WOFF_BITS-1:0] data_wa;
    logic [31:0]           data_wd;

    assign boff    = addr_q[1:0];
    assign woff    = addr_q[WOFF_BITS+1:2];
    assign idx     = addr_q[INDEX_BITS+WOFF_BITS+1:WOFF_BITS+2];
    assign tag     = addr_q[AHI:INDEX_BITS+WOFF_BITS+2];
    assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
    assign acked   = mem_req_q && mem.mem_ack;
    assign last    = (beat_q == {WOFF_BITS{1'b1}});
    assign beat_nx = beat_q + 1'b1;

    // Address bits above the tag alias onto the same lines.
    generate
        if (AHI < 31) begin : g_alias
            logic unused_hi;
            assign unused_hi = ^addr[31:AHI+1];
        end
    endgenerate

    function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] t,
                                              input logic [INDEX_BITS-1:0] i,
                                              input logic [WOFF_BITS-1:0] b);
        logic [31:0] a;
        a = '0;
        a[AHI:0] = {t, i, b, 2'b00};
        return a;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] bo);
        case (size)
            3'b001:  misaligned = 1'b0;
            3'b011:  misaligned = bo[0];
            3'b111:  misaligned = (bo != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] bo,
                                                 input logic [3:0] m);
        logic [31:0] sh, r;
        sh = w >> {bo, 3'b000};
        case (m[2:0])
            3'b001:  r = m[3] ? {{24{sh[7]}}, sh[7:0]}   : {24'b0, sh[7:0]};
            3'b011:  r = m[3] ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                                input logic [1:0] bo, input logic [2:0] size);
        logic [31:0] be, sd;
        case (size)
            3'b001:  be = 32'h0000_00FF;
            3'b011:  be = 32'h0000_FFFF;
            default: be = 32'hFFFF_FFFF;
        endcase
        be = be << {bo, 3'b000};
        sd = d << {bo, 3'b000};
        return (w & ~be) | (sd & be);
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        mask_d      = mask_q;
        wr_d        = wr_q;
        beat_d      = beat_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        read_data_d = read_data_q;
        clk_stall_d = clk_stall_q;
        err_d       = 1'b0;
        data_we     = 1'b0;
        data_wa     = {idx, beat_q};
        data_wd     = mem.mem_rdata;
        fill_done   = 1'b0;
        wb_done     = 1'b0;
        set_dirty   = 1'b0;
        case (state_q)
            IDLE: begin
                addr_d = addr[AHI:0];
                wdat_d = write_data;
                mask_d = sign_mask;
                wr_d   = memwrite && !memread;
                if (memread || memwrite) begin
                    clk_stall_d = 1'b1;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                beat_d = '0;
                if (misaligned(mask_q[2:0], boff)) begin
                    err_d   = 1'b1;
                    state_d = RESPOND;
                end else if (hit) begin
                    state_d = RESPOND;
                end else if (valid_q[idx] && dirty_q[idx]) begin
                    state_d     = WRITEBACK;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = line_addr(tag_mem[idx], idx, {WOFF_BITS{1'b0}});
                    mem_wdata_d = data_mem[{idx, {WOFF_BITS{1'b0}}}];
                end else begin
                    state_d    = REFILL;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr(tag, idx, {WOFF_BITS{1'b0}});
                end
            end
            WRITEBACK: begin
                if (acked) begin
                    beat_d = beat_nx;
                    // The refill burst follows without dropping mem_req.
                    if (last) begin
                        wb_done    = 1'b1;
                        state_d    = REFILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr(tag, idx, {WOFF_BITS{1'b0}});
                    end else begin
                        mem_addr_d  = line_addr(tag_mem[idx], idx, beat_nx);
                        mem_wdata_d = data_mem[{idx, beat_nx}];
                    end
                end
            end
            REFILL: begin
                if (acked) begin
                    data_we = 1'b1;
                    beat_d  = beat_nx;
                    if (last) begin
                        fill_done = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = LOOKUP;
                    end else begin
                        mem_addr_d = line_addr(tag, idx, beat_nx);
                    end
                end
            end
            RESPOND: begin
                clk_stall_d = 1'b0;
                state_d     = IDLE;
                if (!err_q) begin
                    if (wr_q) begin
                        data_we   = 1'b1;
                        data_wa   = {idx, woff};
                        data_wd   = store_merge(data_mem[{idx, woff}], wdat_q, boff, mask_q[2:0]);
                        set_dirty = 1'b1;
                    end else begin
                        read_data_d = load_extract(data_mem[{idx, woff}], boff, mask_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            clk_stall_q <= 1'b0;
            err_q       <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else if (!instr_cache_busy) begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            beat_q      <= beat_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
            clk_stall_q <= clk_stall_d;
            err_q       <= err_d;
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (wb_done)   dirty_q[idx] <= 1'b0;
            if (set_dirty) dirty_q[idx] <= 1'b1;
        end
    end

    // Line storage and the captured request carry no reset.
    always_ff @(posedge clk) begin
        if (!instr_cache_busy) begin
            addr_q <= addr_d;
            wdat_q <= wdat_d;
            mask_q <= mask_d;
            if (data_we)   data_mem[data_wa] <= data_wd;
            if (fill_done) tag_mem[idx]      <= tag;
        end
    end

    assign read_data     = read_data_q;
    assign clk_stall     = clk_stall_q;
    assign err           = err_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: expected beats and load results are queued at issue time.
`timescale 1ns/1ps
module tb_dcache_wb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0, write_data = '0;
    logic        memread = 1'b0, memwrite = 1'b0;
    logic [3:0]  sign_mask = '0;
    logic        instr_cache_busy = 1'b0;
    logic [31:0] read_data;
    logic        clk_stall, err;

    dcache_wb_if mif();

    dcache_wb dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .memread(memread), .memwrite(memwrite), .sign_mask(sign_mask),
        .instr_cache_busy(instr_cache_busy), .read_data(read_data),
        .clk_stall(clk_stall), .err(err), .mem(mif)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] a; logic [31:0] d; } beat_t;
    typedef struct { logic [31:0] rdata; logic err; int hi; } resp_t;

    beat_t       exp_beats[$];
    resp_t       exp_resp[$];
    logic [31:0] bmem [logic [31:0]];
    int          checks = 0, errors = 0, beats_done = 0;
    bit          slow = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 32'h0;
    endfunction

    // Backing memory: acks after a 0..3 cycle delay in slow mode, ignores acks during a freeze.
    initial begin
        beat_t b;
        int    wait_cnt;
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        wait_cnt      = 0;
        forever begin
            @(posedge clk);
            if (rst_n && mif.mem_req && mif.mem_ack && !instr_cache_busy) begin
                if (exp_beats.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got we=%0b addr=0x%08h, required no beat",
                             mif.mem_we, mif.mem_addr);
                end else begin
                    b = exp_beats.pop_front();
                    checks++;
                    if (mif.mem_we !== b.we || mif.mem_addr !== b.a || (b.we && mif.mem_wdata !== b.d)) begin
                        errors++;
                        $display("FAIL beat: got we=%0b addr=0x%08h wdata=0x%08h required we=%0b addr=0x%08h wdata=0x%08h",
                                 mif.mem_we, mif.mem_addr, mif.mem_wdata, b.we, b.a, b.d);
                    end
                end
                if (mif.mem_we) bmem[mif.mem_addr] = mif.mem_wdata;
                beats_done++;
                wait_cnt = slow ? int'($urandom_range(0, 3)) : 0;
            end
            @(negedge clk);
            #1;
            if (rst_n && mif.mem_req) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    mif.mem_ack = 1'b0;
                end else begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = mem_rd(mif.mem_addr);
                end
            end else begin
                mif.mem_ack = 1'b0;
                wait_cnt    = slow ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    // Completion monitor: a falling clk_stall ends a request.
    initial begin
        resp_t r;
        int    hi;
        bit    err_seen, prev;
        hi = 0; err_seen = 1'b0; prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                hi = 0; err_seen = 1'b0; prev = 1'b0;
            end else begin
                if (err) err_seen = 1'b1;
                if (clk_stall) begin
                    hi++;
                end else if (prev) begin
                    if (exp_resp.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_response: got read_data=0x%08h, required none", read_data);
                    end else begin
                        r = exp_resp.pop_front();
                        chk("read_data", read_data, r.rdata);
                        chk("err_pulse", 32'(err_seen), 32'(r.err));
                        if (r.hi >= 0) chk("stall_cycles", 32'(hi), 32'(r.hi));
                    end
                    hi = 0; err_seen = 1'b0;
                end
                prev = clk_stall;
            end
        end
    end

    task automatic push_rd(input logic [31:0] base);
        for (int k = 0; k < 8; k++) exp_beats.push_back('{1'b0, base + 32'(4 * k), 32'h0});
    endtask

    task automatic push_wr(input logic [31:0] base, input logic [31:0] w0, input logic [31:0] kb, input bit inc);
        for (int k = 0; k < 8; k++)
            exp_beats.push_back('{1'b1, base + 32'(4 * k), (k == 0) ? w0 : (inc ? kb + 32'(k) : kb)});
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input logic [31:0] er, input bit ee, input int hi);
        @(negedge clk);
        addr = a; write_data = wd; sign_mask = m; memread = rd; memwrite = wr;
        exp_resp.push_back('{er, ee, hi});
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_resp.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (exp_resp.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d pending responses, required 0", name, exp_resp.size());
            exp_resp.delete();
        end
    endtask

    task automatic wait_beats(input int target, input string name);
        int n = 0;
        while (beats_done < target && n < 300) begin @(negedge clk); n++; end
        if (beats_done < target) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", name, beats_done, target);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_read_data"}, read_data, 32'h0);
        chk({tag, "_clk_stall"}, 32'(clk_stall), 32'h0);
        chk({tag, "_err"},       32'(err), 32'h0);
        chk({tag, "_mem_req"},   32'(mif.mem_req), 32'h0);
        chk({tag, "_mem_we"},    32'(mif.mem_we), 32'h0);
        chk({tag, "_mem_addr"},  mif.mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mif.mem_wdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        for (int k = 0; k < 8; k++) begin
            bmem[32'h40 + 32'(4 * k)] = 32'h1000 + 32'(k);
            bmem[32'h60 + 32'(4 * k)] = 32'h3000 + 32'(k);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_state("reset");

        // Cold miss, hit, then sub-word loads over a stored pattern.
        push_rd(32'h40);
        issue(1, 0, 32'h40, 32'h0, 4'b0111, 32'h1000, 0, 11);  wait_done("cold_miss");
        issue(1, 0, 32'h44, 32'h0, 4'b0111, 32'h1001, 0, 2);   wait_done("hit");
        issue(0, 1, 32'h40, 32'h80F1_7F82, 4'b0111, 32'h1001, 0, 2); wait_done("sw_hit");
        issue(1, 0, 32'h43, 32'h0, 4'b1001, 32'hFFFF_FF80, 0, 2); wait_done("lb");
        issue(1, 0, 32'h43, 32'h0, 4'b0001, 32'h0000_0080, 0, 2); wait_done("lbu");
        issue(1, 0, 32'h42, 32'h0, 4'b1011, 32'hFFFF_80F1, 0, 2); wait_done("lh");
        issue(1, 0, 32'h40, 32'h0, 4'b0011, 32'h0000_7F82, 0, 2); wait_done("lhu");
        issue(1, 0, 32'h42, 32'h0, 4'b0111, 32'h0000_7F82, 1, 2); wait_done("lw_misaligned");
        issue(1, 0, 32'h41, 32'h0, 4'b1011, 32'h0000_7F82, 1, 2); wait_done("lh_misaligned");
        issue(1, 0, 32'h40, 32'h0, 4'b0101, 32'h0000_7F82, 1, 2); wait_done("bad_size");
        issue(1, 1, 32'h44, 32'hFFFF_FFFF, 4'b0111, 32'h1001, 0, 2); wait_done("rd_and_wr");
        issue(1, 0, 32'h44, 32'h0, 4'b0111, 32'h1001, 0, 2);   wait_done("rd_after_both");

        // Fresh cache over a zero line: dirty byte store, then eviction by an aliasing tag.
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_state("reset2");
        for (int k = 0; k < 8; k++) begin
            bmem[32'h40 + 32'(4 * k)]  = 32'h0;
            bmem[32'h140 + 32'(4 * k)] = 32'h2000 + 32'(k);
        end
        push_rd(32'h40);
        issue(0, 1, 32'h41, 32'h1234_56AB, 4'b0001, 32'h0, 0, 11); wait_done("sb_miss");
        push_wr(32'h40, 32'h0000_AB00, 32'h0, 0);
        push_rd(32'h140);
        issue(1, 0, 32'h140, 32'h0, 4'b0111, 32'h2000, 0, 19);  wait_done("evict");
        push_rd(32'h40);
        issue(1, 0, 32'h41, 32'h0, 4'b0001, 32'h0000_00AB, 0, 11); wait_done("reload");

        // Slow memory with a 4-cycle freeze while beat 3 of the refill is outstanding.
        slow = 1'b1;
        b0 = beats_done;
        push_rd(32'h60);
        issue(1, 0, 32'h7C, 32'h0, 4'b0111, 32'h3007, 0, -1);
        wait_beats(b0 + 3, "freeze_start");
        instr_cache_busy = 1'b1;
        repeat (4) @(negedge clk);
        chk("freeze_mem_req", 32'(mif.mem_req), 32'h1);
        chk("freeze_mem_addr", mif.mem_addr, 32'h6C);
        chk("freeze_beats", 32'(beats_done), 32'(b0 + 3));
        instr_cache_busy = 1'b0;
        wait_done("freeze");
        slow = 1'b0;

        // Dirty the line, start its writeback, and reset after three beats.
        issue(0, 1, 32'h60, 32'hDEAD_BEEF, 4'b0111, 32'h3007, 0, 2); wait_done("sw_dirty");
        b0 = beats_done;
        push_wr(32'h60, 32'hDEAD_BEEF, 32'h3000, 1);
        push_rd(32'h160);
        issue(1, 0, 32'h160, 32'h0, 4'b0111, 32'h2000, 0, 19);
        wait_beats(b0 + 3, "wb_reset");
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mif.mem_req), 32'h0);
        chk("abort_clk_stall", 32'(clk_stall), 32'h0);
        chk("abort_beats_left", 32'(exp_beats.size()), 32'd13);
        exp_beats.delete();
        exp_resp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_rd(32'h60);
        issue(1, 0, 32'h6C, 32'h0, 4'b0111, 32'h3003, 0, 11); wait_done("post_reset");

        repeat (3) @(negedge clk);
        chk("beats_left", 32'(exp_beats.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised, direct-mapped, write-back, write-allocate data cache for the RV32I core's load/store path. It replaces the fixed 8-line, write-through-less data cache with one that has configurable geometry, dirty tracking, and a word-serial refill/writeback port to a backing memory. It stalls the core through `clk_stall` and yields to the instruction cache through `instr_cache_busy`.

## Interface
- `WOFF_BITS`, default 3: log2 of words per line (default 8 words, 256-bit line).
- `INDEX_BITS`, default 3: log2 of the number of lines.
- `TAG_BITS`, default 6: tag width. Address bits above `TAG_BITS+INDEX_BITS+WOFF_BITS+2` are ignored (they alias).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address of the load/store.
- `write_data` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `memread` / `memwrite` in 1 each: load/store request, sampled in IDLE.
- `sign_mask` in 4: [2:0] size (001 byte, 011 half, 111 word); [3] sign-extend loads.
- `instr_cache_busy` in 1: while high, the FSM and all registers hold.
- `read_data` out 32: load result; holds its value between loads.
- `clk_stall` out 1: high while a request is in flight.
- `err` out 1: one-cycle pulse on a misaligned or illegal-size request.
- `mem_req` out 1: backing-memory beat request.
- `mem_we` out 1: 1 = write beat, 0 = read beat.
- `mem_addr` out 32: word address of the beat (line base + 4·beat).
- `mem_wdata` out 32: writeback data.
- `mem_rdata` in 32: refill data, valid with `mem_ack`.
- `mem_ack` in 1: completes the current beat.

## Operation
- **Storage and address split.** Each of the 2^INDEX_BITS lines holds data, a tag, `valid` and `dirty`. The address splits as byte offset [1:0], word offset, index, then tag.
- **States:** IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- **IDLE**
  - Registers `addr`, `write_data`, `sign_mask`, `memread` and `memwrite`.
  - If either request is high: `clk_stall` goes to 1 and the FSM moves to LOOKUP.
  - If both are high, the request is treated as a read.
- **Alignment check (in LOOKUP).** A request is faulting if it is a halfword with addr[0]=1, a word with addr[1:0]≠0, or its size is not 001/011/111. A faulting request:
  - pulses `err`;
  - goes to RESPOND with no cache or memory change;
  - leaves `read_data` unchanged.
- **LOOKUP, hit** (valid and tag equal): go to RESPOND.
- **LOOKUP, miss:** go to WRITEBACK if the victim is valid and dirty, otherwise to REFILL.
- **WRITEBACK**
  - Issues 2^WOFF_BITS write beats, beat 0 first, to the victim's address {old tag, index, beat, 00}.
  - Then clears `dirty` and goes to REFILL.
- **REFILL**
  - Issues 2^WOFF_BITS read beats and writes each `mem_rdata` into the line.
  - On the last ack: sets the tag, `valid`=1, `dirty`=0, and returns to LOOKUP, which then hits.
- **RESPOND**
  - Load: `read_data` ← the selected byte/half/word, zero- or sign-extended per `sign_mask[3]`.
  - Store: merges the byte/half/word into the addressed word at its byte offset and sets `dirty`=1.
  - Drops `clk_stall` and returns to IDLE.
- **Reset** clears every `valid` and `dirty` bit. Line data and tags are not reset.

## Timing
- **Reset values:** `read_data`=0, `clk_stall`=0, `err`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0; FSM in IDLE.
- **Hit latency.** The request is sampled at edge E0 and `clk_stall` is high after E0. The FSM is in LOOKUP after E0 and in RESPOND after E1. `read_data` is valid and `clk_stall` is 0 after E2.
- **Miss latency:** 3 + Σ(beat cycles). Beat cycles = 2^WOFF_BITS beats of refill, plus 2^WOFF_BITS beats of writeback if the victim is dirty.
- **Memory handshake.**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered and held stable until a cycle with `mem_ack`=1.
  - The next beat's request is presented on the following cycle, with `mem_req` continuously high between beats of the same burst.
  - `mem_req` falls the cycle after the last ack.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Zero-wait (ack on the first request cycle) must work; a refill then takes exactly 2^WOFF_BITS cycles.
- **`instr_cache_busy`=1:** no state, register or output change. In-progress `mem_req` stays asserted, and an ack arriving in that cycle is dropped; memory re-acks after the freeze.
- **`rst_n` low mid-burst:** immediate abort. `mem_req` drops asynchronously and dirty data is discarded.
- **Back-to-back requests:** a new request can be sampled on the first IDLE cycle after RESPOND.

## Test plan
- **Cold miss, then hit.** Load word from 0x40, where memory word k of that line = 0x1000+k. Expect `read_data`=0x1000, 8 read beats at 0x40..0x5C, no write beats. A second load at 0x44 returns 0x1001 with 3-edge latency and no `mem_req`.
- **Byte/half loads.** The word at 0x40 holds 0x80F1_7F82. Expected results:
  - LB at 0x43 → 0xFFFF_FF80;
  - LBU at 0x43 → 0x0000_0080;
  - LH at 0x42 → 0xFFFF_80F1;
  - LHU at 0x40 → 0x0000_7F82.
- **Store then evict.** SB 0xAB at 0x41, then a load from 0x140 (same index, tag differs). Expect 8 write beats at 0x40..0x5C with beat 0 = 0x0000_AB00 over a zero line, followed by 8 read beats at 0x140.
- **Misaligned request.** LW at 0x42 → `err` pulses, no memory beats, `read_data` unchanged, `clk_stall` low after 3 edges.
- **Freeze and slow ack.** Hold `instr_cache_busy`=1 for 4 cycles during REFILL beat 3, with random 0–3-cycle ack delays. Expect all 8 beats to complete in order and the correct data to be returned.
- **Reset during writeback.** Assert `rst_n`=0 after beat 2. Expect `mem_req`=0 immediately and `clk_stall`=0. A subsequent load from the old address misses and refills from memory.
